fp_align_comp_pipe: RTL and testbench

//  Two-stage pipelined front end for the FP add/sub datapath: aligns the smaller mantissa, then conditionally complements it.

---
 rtl/fp_align_comp_pipe.sv | 116 +++++++++++
 tb/tb_fp_align_comp_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_comp_pipe.sv
// fp_align_comp_pipe
//   Two-stage pipelined front end for the FP add/sub mantissa datapath.
//   Stage 1 right-shifts the smaller mantissa by the exponent difference and
//   collects a sticky bit from everything shifted out. Stage 2 resolves the
//   effective operation and produces the signed addend for the mantissa adder
//   (plain, two's-complemented or one's-complemented depending on ONES_COMP).
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready does not depend on in_valid)
//   sign_A, sign_B      operand signs
//   funct               0 = add, 1 = subtract
//   exp_diff            unsigned right-shift amount for small_mant
//   small_mant          unaligned smaller mantissa (hidden bit included)
//   out_valid/out_ready output handshake
//   eff_sub             effective subtract flag of the output beat
//   twos_mant           aligned, conditionally complemented mantissa, signed
//   sticky              OR of all bits shifted out in stage 1
module fp_align_comp_pipe #(
    parameter int MANT_W    = 6,
    parameter int SHIFT_W   = 3,
    parameter int ONES_COMP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_A,
    input  logic              sign_B,
    input  logic              funct,
    input  logic [SHIFT_W-1:0] exp_diff,
    input  logic [MANT_W-1:0] small_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              eff_sub,
    output logic [MANT_W:0]   twos_mant,
    output logic              sticky
);

    logic              s1_valid;
    logic [MANT_W-1:0] s1_sh;
    logic              s1_st;
    logic              s1_es;
    logic              s2_valid;

    logic              s1_adv;
    logic              s2_adv;

    logic [MANT_W-1:0] sh_val;
    logic [MANT_W-1:0] lost_mask;
    logic              st_val;
    logic              es_val;
    logic [MANT_W:0]   ext;
    logic [MANT_W:0]   addend;

    // A stage may load when it is empty or the stage after it is draining.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign out_valid = s2_valid;

    // Alignment: a logical shift of MANT_W or more yields zero, and the lost-bit
    // mask then covers the whole mantissa, so sticky becomes |small_mant.
    always_comb begin
        sh_val    = small_mant >> exp_diff;
        lost_mask = ~({MANT_W{1'b1}} << exp_diff);
        st_val    = |(small_mant & lost_mask);
        es_val    = sign_A ^ sign_B ^ funct;
    end

    // Complement step on the zero-extended value; the extra MSB keeps the
    // result an unambiguous signed number (-0 stays 0 in two's mode).
    always_comb begin
        ext = {1'b0, s1_sh};
        if (!s1_es) begin
            addend = ext;
        end else if (ONES_COMP != 0) begin
            addend = ~ext;
        end else begin
            addend = -ext;
        end
    end

    // Pipeline registers; data only loads alongside a valid beat so bubbles
    // leave the previous data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sh     <= '0;
            s1_st     <= 1'b0;
            s1_es     <= 1'b0;
            s2_valid  <= 1'b0;
            twos_mant <= '0;
            sticky    <= 1'b0;
            eff_sub   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sh <= sh_val;
                    s1_st <= st_val;
                    s1_es <= es_val;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    twos_mant <= addend;
                    sticky    <= s1_st;
                    eff_sub   <= s1_es;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_align_comp_pipe.sv
// tb_fp_align_comp_pipe
//   Self-checking bench for fp_align_comp_pipe (MANT_W=6, SHIFT_W=3). Two
//   instances share the input stream: one in two's-complement mode, one in
//   one's-complement mode. Expected results come from an arithmetic model
//   holding in-flight beats in a queue with their age in clock edges.
module tb_fp_align_comp_pipe;

    localparam int MW = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          sign_A = 1'b0;
    logic          sign_B = 1'b0;
    logic          funct = 1'b0;
    logic [SW-1:0] exp_diff = '0;
    logic [MW-1:0] small_mant = '0;
    logic          out_ready = 1'b0;

    logic          in_ready0, out_valid0, eff_sub0, sticky0;
    logic [MW:0]   twos_mant0;
    logic          in_ready1, out_valid1, eff_sub1, sticky1;
    logic [MW:0]   twos_mant1;

    int tests_run = 0;
    int failures  = 0;

    typedef struct {
        int         age;
        logic       es;
        logic [6:0] t2;
        logic [6:0] t1;
        logic       st;
    } beat_t;

    beat_t q[$];

    fp_align_comp_pipe #(.MANT_W(MW), .SHIFT_W(SW), .ONES_COMP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .sign_A(sign_A), .sign_B(sign_B), .funct(funct), .exp_diff(exp_diff),
        .small_mant(small_mant), .out_valid(out_valid0), .out_ready(out_ready),
        .eff_sub(eff_sub0), .twos_mant(twos_mant0), .sticky(sticky0)
    );

    fp_align_comp_pipe #(.MANT_W(MW), .SHIFT_W(SW), .ONES_COMP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .sign_A(sign_A), .sign_B(sign_B), .funct(funct), .exp_diff(exp_diff),
        .small_mant(small_mant), .out_valid(out_valid1), .out_ready(out_ready),
        .eff_sub(eff_sub1), .twos_mant(twos_mant1), .sticky(sticky1)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports a mismatch through $error.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result of one beat, straight from the arithmetic definition.
    function automatic beat_t model(input logic sa, input logic sb, input logic f,
                                    input int d, input int m);
        beat_t b;
        int    div;
        int    sh;
        div   = 1 << d;
        sh    = m / div;
        b.age = 1;
        b.es  = sa ^ sb ^ f;
        b.st  = (m % div) != 0;
        b.t2  = 7'(b.es ? (128 - sh) % 128 : sh);
        b.t1  = 7'(b.es ? 127 - sh : sh);
        return b;
    endfunction

    // Drives one cycle of stimulus, checks outputs at the falling edge, then
    // advances the model across the rising edge.
    task automatic applyStimulus(input logic v, input logic sa, input logic sb, input logic f,
                                 input logic [SW-1:0] d, input logic [MW-1:0] m,
                                 input logic ordy, output logic accepted);
        logic  exp_ready;
        logic  exp_ov;
        logic  drained;
        beat_t nb;
        in_valid   = v;
        sign_A     = sa;
        sign_B     = sb;
        funct      = f;
        exp_diff   = d;
        small_mant = m;
        out_ready  = ordy;
        @(negedge clk);
        exp_ready = (q.size() < 2) || ordy;
        exp_ov    = (q.size() > 0) && (q[0].age >= 2);
        checkOutput("in_ready0", 32'(in_ready0), 32'(exp_ready));
        checkOutput("in_ready1", 32'(in_ready1), 32'(exp_ready));
        checkOutput("out_valid0", 32'(out_valid0), 32'(exp_ov));
        checkOutput("out_valid1", 32'(out_valid1), 32'(exp_ov));
        if (exp_ov) begin
            checkOutput("eff_sub0", 32'(eff_sub0), 32'(q[0].es));
            checkOutput("eff_sub1", 32'(eff_sub1), 32'(q[0].es));
            checkOutput("sticky0", 32'(sticky0), 32'(q[0].st));
            checkOutput("sticky1", 32'(sticky1), 32'(q[0].st));
            checkOutput("twos_mant0", 32'(twos_mant0), 32'(q[0].t2));
            checkOutput("twos_mant1", 32'(twos_mant1), 32'(q[0].t1));
        end
        accepted = v && exp_ready;
        drained  = exp_ov && ordy;
        nb = model(sa, sb, f, int'(d), int'(m));
        @(posedge clk);
        if (drained) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (accepted) q.push_back(nb);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ordy, acc);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            idle(1, 1'b1);
            budget++;
        end
        checkOutput("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic       acc;
        int         k;
        int         budget;
        logic [5:0] stream_m [4];
        logic [2:0] stream_d [4];

        // Reset state
        rst = 1'b1;
        #12;
        checkOutput("rst_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready0), 32'd1);
        checkOutput("rst_twos_mant", 32'(twos_mant0), 32'd0);
        checkOutput("rst_sticky", 32'(sticky0), 32'd0);
        checkOutput("rst_eff_sub", 32'(eff_sub0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed 1: subtract with exact shift
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 6'b101100, 1'b1, acc);
        idle(1, 1'b1);
        checkOutput("d1_out_valid", 32'(out_valid0), 32'd1);
        checkOutput("d1_eff_sub", 32'(eff_sub0), 32'd1);
        checkOutput("d1_twos_mant", 32'(twos_mant0), 32'b1110101);
        checkOutput("d1_sticky", 32'(sticky0), 32'd0);
        drain();

        // Directed 2: add with sticky
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 6'b000111, 1'b1, acc);
        idle(1, 1'b1);
        checkOutput("d2_twos_mant", 32'(twos_mant0), 32'b0000001);
        checkOutput("d2_sticky", 32'(sticky0), 32'd1);
        checkOutput("d2_eff_sub", 32'(eff_sub0), 32'd0);
        drain();

        // Directed 3: shift past the mantissa, both complement modes
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 6'b100001, 1'b1, acc);
        idle(1, 1'b1);
        checkOutput("d3_twos_mant", 32'(twos_mant0), 32'd0);
        checkOutput("d3_sticky", 32'(sticky0), 32'd1);
        checkOutput("d3_ones_mant", 32'(twos_mant1), 32'b1111111);
        checkOutput("d3_eff_sub", 32'(eff_sub1), 32'd1);
        drain();

        // Directed 4: four-beat stream with output stalled for three cycles
        for (int i = 0; i < 4; i++) begin
            stream_m[i] = 6'($urandom_range(63));
            stream_d[i] = 3'($urandom_range(7));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, stream_d[0], stream_m[0], 1'b0, acc);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, stream_d[1], stream_m[1], 1'b0, acc);
        checkOutput("stall_in_ready", 32'(in_ready0), 32'd0);
        checkOutput("stall_out_valid", 32'(out_valid0), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, stream_d[2], stream_m[2], 1'b0, acc);
        checkOutput("stall_no_accept", 32'(acc), 32'd0);
        k = 2;
        budget = 0;
        while (k < 4 && budget < 20) begin
            applyStimulus(1'b1, 1'b1, k[0], 1'b1, stream_d[k], stream_m[k], 1'b1, acc);
            if (acc) k++;
            budget++;
        end
        checkOutput("stream_accept_timeout", 32'(k), 32'd4);
        drain();

        // Directed 5: 16 back-to-back random beats with no back-pressure
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                          3'($urandom_range(7)), 6'($urandom_range(63)), 1'b1, acc);
            checkOutput("burst_accept", 32'(acc), 32'd1);
        end
        drain();

        // Directed 6: reset with two beats in flight
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 6'b110011, 1'b1, acc);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 6'b011101, 1'b1, acc);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("mid_rst_twos_mant", 32'(twos_mant0), 32'd0);
        checkOutput("mid_rst_sticky", 32'(sticky0), 32'd0);
        checkOutput("mid_rst_eff_sub", 32'(eff_sub0), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready0), 32'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4, 1'b1);

        // Mixed random traffic with random back-pressure
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          3'($urandom_range(7)), 6'($urandom_range(63)),
                          1'($urandom_range(3) != 0), acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
